// File: rtl/clb_cfg_pkg.sv
// clb_cfg_pkg
//   Shared definitions for the CLB configuration loader and for the CLB
//   wrapper that decodes the per-slot configuration frame.
//   Contents: loader state enum, framing constants (preamble, length-field
//   width, postamble length), the reset frame value and the bit offsets and
//   widths of every field inside a 37-bit frame.
package clb_cfg_pkg;

  typedef enum logic [2:0] {
    ST_HUNT  = 3'd0,
    ST_LEN   = 3'd1,
    ST_FRAME = 3'd2,
    ST_POST  = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERR   = 3'd5
  } cfg_state_e;

  localparam int         CFG_W       = 37;
  localparam int         FRAME_BITS  = CFG_W + 1;   // data bits plus parity bit
  localparam logic [7:0] PREAMBLE    = 8'hF2;
  localparam int         LEN_W       = 16;
  localparam int         POST_LEN    = 4;
  localparam int         SHIFT_CNT_W = 6;           // counts up to FRAME_BITS-1

  localparam logic [CFG_W-1:0] CFG_DEFAULT = 37'h3_80A8_0116;

  // Frame field layout (LSB first)
  localparam int MEM_OFF         = 0;
  localparam int MEM_W           = 16;
  localparam int COMBOPTION_OFF  = 16;
  localparam int COMBOPTION_W    = 2;
  localparam int MUX2SEL_OFF     = 18;
  localparam int MUX3SEL_OFF     = 20;
  localparam int MUX4SEL_OFF     = 22;
  localparam int MUX5SEL_OFF     = 24;
  localparam int MUX6SEL_OFF     = 26;
  localparam int MUXSEL_W        = 2;
  localparam int O2M1_0_OFF      = 28;
  localparam int O2M2_0_OFF      = 29;
  localparam int O2M3_0_OFF      = 30;
  localparam int O2M1_1_OFF      = 31;
  localparam int O2M2_1_OFF      = 32;
  localparam int O2M3_1_OFF      = 33;
  localparam int DQMUX1_OFF      = 34;
  localparam int DQMUX2_OFF      = 35;
  localparam int FLOPORLATCH_OFF = 36;

endpackage

// File: rtl/clb_cfg_shifter.sv
// clb_cfg_shifter
//   Serial-in shift path with running parity and accepted-bit counter.
//   data_o presents the W most recent bits including the bit on din_i this
//   cycle, so the caller can act on a complete word in the same cycle that
//   its last bit is accepted. Only W-1 bits need storage for that.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clr_i         : synchronous clear of window, parity and counter
//   en_i          : accept din_i this cycle
//   din_i         : serial bit
//   data_o        : {stored bits, din_i}, newest bit at LSB
//   par_o         : XOR of all accepted bits since clear, including din_i
//   cnt_o         : number of bits accepted since clear (wraps)
module clb_cfg_shifter
  import clb_cfg_pkg::*;
#(
  parameter int W     = FRAME_BITS,
  parameter int CNT_W = SHIFT_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             din_i,
  output logic [W-1:0]     data_o,
  output logic             par_o,
  output logic [CNT_W-1:0] cnt_o
);

  logic [W-2:0]     sr_q;
  logic             par_q;
  logic [CNT_W-1:0] cnt_q;

  assign data_o = {sr_q, din_i};
  assign par_o  = par_q ^ din_i;
  assign cnt_o  = cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sr_q  <= '0;
      par_q <= 1'b0;
      cnt_q <= '0;
    end else if (clr_i) begin
      sr_q  <= '0;
      par_q <= 1'b0;
      cnt_q <= '0;
    end else if (en_i) begin
      sr_q  <= data_o[W-2:0];
      par_q <= par_o;
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/clb_cfg_loader.sv
// clb_cfg_loader
//   Serial configuration controller for the CLB array. Hunts for the
//   preamble, checks the slot-count field, loads one parity-protected frame
//   per CLB slot and checks the all-ones postamble.
// Ports:
//   K        : clock
//   RST_N    : asynchronous active-low reset (slots return to CFG_DEFAULT)
//   DIN      : serial configuration bit, MSB first
//   DVALID   : DIN valid this cycle
//   RESTART  : synchronous abort, back to preamble hunt, slots kept
//   CFG      : flat slot bus, slot i at [i*CFG_W +: CFG_W]
//   CFG_STB  : one-cycle pulse when a slot is written
//   CFG_IDX  : slot index written, valid with CFG_STB
//   BUSY     : load in progress (preamble seen, not yet DONE/ERR)
//   DONE     : sticky, load completed
//   ERR      : sticky, bitstream rejected
module clb_cfg_loader #(
  parameter  int NCLB  = 4,
  parameter  int CFG_W = 37,
  localparam int IDX_W = (NCLB > 1) ? $clog2(NCLB) : 1
) (
  input  logic                  K,
  input  logic                  RST_N,
  input  logic                  DIN,
  input  logic                  DVALID,
  input  logic                  RESTART,
  output logic [NCLB*CFG_W-1:0] CFG,
  output logic                  CFG_STB,
  output logic [IDX_W-1:0]      CFG_IDX,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  ERR
);
  import clb_cfg_pkg::*;

  localparam int FRAME_W = CFG_W + 1;

  cfg_state_e             state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   stb_q, stb_d;
  logic [IDX_W-1:0]       cfg_idx_q;
  logic [CFG_W-1:0]       slot_q [NCLB];

  logic                   sh_clr, sh_en, wr_en;
  logic [FRAME_W-1:0]     sh_data;
  logic                   sh_par;
  logic [SHIFT_CNT_W-1:0] sh_cnt;

  // The same shift path serves as the 8-bit preamble window (low byte),
  // the 16-bit length field and the 38-bit frame.
  clb_cfg_shifter #(
    .W     (FRAME_W),
    .CNT_W (SHIFT_CNT_W)
  ) u_shifter (
    .clk_i  (K),
    .rst_ni (RST_N),
    .clr_i  (sh_clr),
    .en_i   (sh_en),
    .din_i  (DIN),
    .data_o (sh_data),
    .par_o  (sh_par),
    .cnt_o  (sh_cnt)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    stb_d   = 1'b0;
    sh_clr  = 1'b0;
    sh_en   = 1'b0;
    wr_en   = 1'b0;
    if (RESTART) begin
      // Abort wins over a simultaneous valid bit; that bit is dropped.
      state_d = ST_HUNT;
      idx_d   = '0;
      sh_clr  = 1'b1;
    end else if (DVALID) begin
      case (state_q)
        ST_HUNT: begin
          sh_en = 1'b1;
          if (sh_data[7:0] == PREAMBLE) begin
            state_d = ST_LEN;
            sh_clr  = 1'b1;
          end
        end
        ST_LEN: begin
          sh_en = 1'b1;
          if (sh_cnt == SHIFT_CNT_W'(LEN_W - 1)) begin
            sh_clr = 1'b1;
            if (sh_data[LEN_W-1:0] == LEN_W'(NCLB)) begin
              state_d = ST_FRAME;
              idx_d   = '0;
            end else begin
              state_d = ST_ERR;
            end
          end
        end
        ST_FRAME: begin
          sh_en = 1'b1;
          if (sh_cnt == SHIFT_CNT_W'(FRAME_W - 1)) begin
            sh_clr = 1'b1;
            // sh_par is the XOR over all 38 bits; odd count means bad frame.
            if (sh_par) begin
              state_d = ST_ERR;
            end else begin
              wr_en = 1'b1;
              stb_d = 1'b1;
              if (idx_q == IDX_W'(NCLB - 1)) begin
                state_d = ST_POST;
              end else begin
                idx_d = idx_q + IDX_W'(1);
              end
            end
          end
        end
        ST_POST: begin
          sh_en = 1'b1;
          if (!DIN) begin
            state_d = ST_ERR;
          end else if (sh_cnt == SHIFT_CNT_W'(POST_LEN - 1)) begin
            state_d = ST_DONE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge K or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= ST_HUNT;
      idx_q     <= '0;
      stb_q     <= 1'b0;
      cfg_idx_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      stb_q   <= stb_d;
      if (wr_en) begin
        cfg_idx_q <= idx_q;
      end
    end
  end

  // Slot register file: reset restores the default frame, RESTART does not.
  always_ff @(posedge K or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NCLB; i++) begin
        slot_q[i] <= CFG_W'(CFG_DEFAULT);
      end
    end else if (wr_en) begin
      slot_q[idx_q] <= sh_data[FRAME_W-1:1];
    end
  end

  for (genvar g = 0; g < NCLB; g++) begin : g_cfg
    assign CFG[g*CFG_W +: CFG_W] = slot_q[g];
  end

  assign CFG_STB = stb_q;
  assign CFG_IDX = cfg_idx_q;
  assign BUSY    = (state_q == ST_LEN) || (state_q == ST_FRAME) || (state_q == ST_POST);
  assign DONE    = (state_q == ST_DONE);
  assign ERR     = (state_q == ST_ERR);

endmodule
